full_sub: RTL and testbench
===========================

Name: full_sub

Overview:
- Ripple-borrow subtractor: computes a - b - cin with borrow-out.
- Built from a chain of 1-bit full-subtractor cells.
- Default WIDTH=1 is the plain 1-bit full subtractor used as the datapath subtract primitive (ALU subtract path).
- Provides combinational results for same-cycle use, plus registered copies cleared by synchronous reset.

Parameters:
- WIDTH, 1, operand/result width in bits (>=1).

Ports:
- clk  input  1  system clock; all registers update on rising edge.
- rst  input  1  synchronous, active-high reset; clears registered outputs only.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- cin  input  1  borrow-in (1 = subtract an extra 1).
- s  output  WIDTH  combinational difference, a - b - cin mod 2^WIDTH.
- cout  output  1  combinational borrow-out; 1 when unsigned a < b + cin.
- ovf  output  1  combinational signed-overflow flag for two's-complement a - b - cin.
- s_q  output  WIDTH  s registered on rising clk.
- cout_q  output  1  cout registered on rising clk.
- ovf_q  output  1  ovf registered on rising clk.

Behaviour:
- Per-bit cell i, with borrow-in bi (b0 = cin):
  - d_i = a_i ^ b_i ^ bi
  - bo_i = (~a_i & b_i) | (~a_i & bi) | (b_i & bi)
  - bo_i feeds b(i+1).
  - cout = bo of bit WIDTH-1.
- s, cout, ovf are purely combinational:
  - Zero-cycle latency; no dependence on clk or rst.
  - Must settle within the same cycle the inputs change.
- ovf = (a[MSB] != b[MSB]) & (s[MSB] != a[MSB]).
  - For WIDTH=1, same formula on bit 0.
- Registered outputs:
  - On rising clk with rst=1: s_q=0, cout_q=0, ovf_q=0.
  - Otherwise they capture s, cout, ovf.
  - Latency exactly 1 cycle.
- rst has no effect on the combinational outputs; they stay valid during reset.
- Wrap-around: results modulo 2^WIDTH.
  - 0 - 0 - 1 gives s = all ones, cout = 1.
  - max - max - 0 gives s = 0, cout = 0.
- X/Z on inputs is not a supported condition.
- No handshake and no state machine.

Decomposition:
- No shared package needed. WIDTH is the only parameter; no typedefs.
- Sub-module full_sub_cell: 1-bit full subtractor (a, b, bin -> d, bout), instantiated WIDTH times by a generate loop.
- Output registers and ovf logic live in full_sub.

Test Plan:
- WIDTH=1, exhaustive 8 rows, (a b cin -> s cout), checked combinationally mid-cycle:
  - 000->00, 001->11, 010->11, 011->01
  - 100->10, 101->00, 110->00, 111->11
- WIDTH=8, a=0x05, b=0x07, cin=0 -> s=0xFE, cout=1, ovf=0; next cycle s_q=0xFE, cout_q=1.
- WIDTH=8, a=0x10, b=0x01, cin=1 -> s=0x0E, cout=0, ovf=0.
- WIDTH=8, a=0x80, b=0x01, cin=0 -> s=0x7F, cout=0, ovf=1.
- WIDTH=8, a=0x00, b=0x00, cin=1 -> s=0xFF, cout=1, ovf=0 (wrap-around).
- Assert rst=1 for one cycle while a=0x05, b=0x07:
  - Registered outputs s_q, cout_q, ovf_q = 0 after that edge.
  - Combinational s=0xFE, cout=1 unaffected throughout.
  - After rst=0, s_q=0xFE on the next edge.

Source files
------------

// File: rtl/full_sub_cell.sv
// ---------------------------------------------------------------------------
// full_sub_cell
//   One-bit full subtractor: computes a - b - bin, giving the difference bit
//   and the borrow into the next more significant bit.
//
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow-in from the less significant bit (or the external borrow-in)
//   d    : difference bit
//   bout : borrow-out to the more significant bit
// ---------------------------------------------------------------------------
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow whenever the bit cannot cover b plus the incoming borrow.
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/full_sub.sv
// ---------------------------------------------------------------------------
// full_sub
//   Ripple-borrow subtractor computing a - b - cin, modulo 2^WIDTH.
//   The combinational results (s, cout, ovf) are valid in the same cycle the
//   inputs change and ignore rst. Registered copies (s_q, cout_q, ovf_q)
//   follow one clock later and are cleared by synchronous reset.
//   WIDTH=1 is the plain 1-bit full subtractor used on the ALU subtract path.
//
// Parameters:
//   WIDTH  : operand/result width in bits (>= 1)
//
// Ports:
//   clk    : system clock, rising-edge active
//   rst    : synchronous active-high reset, clears registered outputs only
//   a      : minuend
//   b      : subtrahend
//   cin    : borrow-in (1 = subtract an extra 1)
//   s      : combinational difference
//   cout   : combinational borrow-out (1 when unsigned a < b + cin)
//   ovf    : combinational two's-complement overflow flag
//   s_q    : s registered
//   cout_q : cout registered
//   ovf_q  : ovf registered
// ---------------------------------------------------------------------------
module full_sub #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             ovf_q
);

  // Signed overflow of a - b: only possible when the operand signs differ,
  // and then it happened if the result sign disagrees with the minuend.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb != b_msb) && (s_msb != a_msb);
  endfunction

  // Borrow chain: bchain[0] is the external borrow-in, bchain[WIDTH] the
  // borrow-out of the most significant cell.
  logic [WIDTH:0] bchain;

  assign bchain[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_sub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (bchain[i]),
      .d    (s[i]),
      .bout (bchain[i+1])
    );
  end

  assign cout = bchain[WIDTH];
  assign ovf  = sub_ovf(a[WIDTH-1], b[WIDTH-1], s[WIDTH-1]);

  // ---- stage boundary: combinational result -> registered copies ----------
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_full_sub.sv
module tb_full_sub;

  logic       clk = 1'b0;
  logic       rst;

  // WIDTH=1 instance
  logic       a1, b1, cin1;
  logic       s1, cout1, ovf1, s1_q, cout1_q, ovf1_q;

  // WIDTH=8 instance
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] s8, s8_q;
  logic       cout8, ovf8, cout8_q, ovf8_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  full_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .ovf(ovf1),
    .s_q(s1_q), .cout_q(cout1_q), .ovf_q(ovf1_q)
  );

  full_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .ovf(ovf8),
    .s_q(s8_q), .cout_q(cout8_q), .ovf_q(ovf8_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  task automatic model8(input int a, input int b, input int c,
                        output logic [7:0] s, output logic co, output logic ov);
    int d, sa, sb, sd;
    d  = a - b - c;
    s  = 8'(d & 255);
    co = (a < b + c);
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sd = sa - sb - c;
    ov = (sd > 127) || (sd < -128);
  endtask

  task automatic model1(input int a, input int b, input int c,
                        output logic s, output logic co, output logic ov);
    int d, sd;
    d  = a - b - c;
    s  = d[0];
    co = (a < b + c);
    // A single bit read as two's complement is 0 or -1.
    sd = (-a) - (-b) - c;
    ov = (sd > 0) || (sd < -1);
  endtask

  logic [7:0] es8;
  logic       eco8, eov8;
  logic       es1, eco1, eov1;
  logic [7:0] ps8;
  logic       pco8, pov8, ps1, pco1, pov1;

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0;
    a8 = 8'h05; b8 = 8'h07; cin8 = 0;

    // Reset state, with combinational path unaffected by rst
    @(posedge clk); @(posedge clk); #1;
    chk("rst_s_q", 32'(s8_q), 0);
    chk("rst_cout_q", 32'(cout8_q), 0);
    chk("rst_ovf_q", 32'(ovf8_q), 0);
    chk("rst_s1_q", 32'(s1_q), 0);
    chk("rst_comb_s", 32'(s8), 32'hFE);
    chk("rst_comb_cout", 32'(cout8), 1);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=1 exhaustive truth table (spec constants)
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] row [8];
      row = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
      v = 3'(i);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0];
      #1;
      model1(int'(v[2]), int'(v[1]), int'(v[0]), es1, eco1, eov1);
      chk($sformatf("w1_s_%0d", i), 32'(s1), 32'(row[i][1]));
      chk($sformatf("w1_cout_%0d", i), 32'(cout1), 32'(row[i][0]));
      chk($sformatf("w1_ovf_%0d", i), 32'(ovf1), 32'(eov1));
      @(posedge clk); #1;
      chk($sformatf("w1_s_q_%0d", i), 32'(s1_q), 32'(row[i][1]));
    end

    // WIDTH=8 directed vectors
    drive8(8'h05, 8'h07, 1'b0);
    chk("d1_s", 32'(s8), 32'hFE); chk("d1_cout", 32'(cout8), 1); chk("d1_ovf", 32'(ovf8), 0);
    @(posedge clk); #1;
    chk("d1_s_q", 32'(s8_q), 32'hFE); chk("d1_cout_q", 32'(cout8_q), 1);

    drive8(8'h10, 8'h01, 1'b1);
    chk("d2_s", 32'(s8), 32'h0E); chk("d2_cout", 32'(cout8), 0); chk("d2_ovf", 32'(ovf8), 0);

    drive8(8'h80, 8'h01, 1'b0);
    chk("d3_s", 32'(s8), 32'h7F); chk("d3_cout", 32'(cout8), 0); chk("d3_ovf", 32'(ovf8), 1);
    @(posedge clk); #1;
    chk("d3_ovf_q", 32'(ovf8_q), 1);

    drive8(8'h00, 8'h00, 1'b1);
    chk("d4_s", 32'(s8), 32'hFF); chk("d4_cout", 32'(cout8), 1); chk("d4_ovf", 32'(ovf8), 0);

    drive8(8'hFF, 8'hFF, 1'b0);
    chk("d5_s", 32'(s8), 0); chk("d5_cout", 32'(cout8), 0);

    // One-cycle reset pulse mid-run
    drive8(8'h05, 8'h07, 1'b0);
    rst = 1'b1;
    chk("r_comb_s", 32'(s8), 32'hFE);
    @(posedge clk); #1;
    chk("r_s_q", 32'(s8_q), 0); chk("r_cout_q", 32'(cout8_q), 0); chk("r_ovf_q", 32'(ovf8_q), 0);
    chk("r_comb_s2", 32'(s8), 32'hFE); chk("r_comb_cout2", 32'(cout8), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("r_after_s_q", 32'(s8_q), 32'hFE);
    chk("r_after_cout_q", 32'(cout8_q), 1);

    // Randomized vectors on both widths, combinational and registered
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
      cin1 = 1'($urandom_range(0, 1));
      #1;
      model8(int'(a8), int'(b8), int'(cin8), es8, eco8, eov8);
      model1(int'(a1), int'(b1), int'(cin1), es1, eco1, eov1);
      chk("rnd_s8", 32'(s8), 32'(es8));
      chk("rnd_cout8", 32'(cout8), 32'(eco8));
      chk("rnd_ovf8", 32'(ovf8), 32'(eov8));
      chk("rnd_s1", 32'(s1), 32'(es1));
      chk("rnd_cout1", 32'(cout1), 32'(eco1));
      chk("rnd_ovf1", 32'(ovf1), 32'(eov1));
      ps8 = es8; pco8 = eco8; pov8 = eov8;
      ps1 = es1; pco1 = eco1; pov1 = eov1;
      @(posedge clk); #1;
      chk("rnd_s8_q", 32'(s8_q), 32'(ps8));
      chk("rnd_cout8_q", 32'(cout8_q), 32'(pco8));
      chk("rnd_ovf8_q", 32'(ovf8_q), 32'(pov8));
      chk("rnd_s1_q", 32'(s1_q), 32'(ps1));
      chk("rnd_cout1_q", 32'(cout1_q), 32'(pco1));
      chk("rnd_ovf1_q", 32'(ovf1_q), 32'(pov1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
